issue_ctrl: RTL
===============

# issue_ctrl

Single-issue dispatch controller between the instruction decoder and the execution units (ASB, LOGIC, LOAD, STORE). Accepts one decoded 57-bit bundle at a time and holds it in a one-entry register. Stalls it on register hazards tracked by a 32-entry scoreboard, then dispatches it to the selected unit over a valid/ready handshake. It also serialises control flow: it waits for redirect after a branch and traps on illegal instructions.

## Interface
- No parameters; bundle width 57 and register count 32 are fixed package constants.
- i_clk  in  1  clock; all state updates on rising edge
- i_rst_n  in  1  reset, asynchronous, active-low
- i_req  in  1  decoder is presenting an instruction
- i_bundle  in  57  decoder bundle: rs1[56:52], rs2[51:47], rd[46:42], unit[41:39], op[38:36], func[35:33], imm[32:1], branch[0]
- i_valid  in  1  decoder legality flag for i_bundle
- o_ready  out  1  instruction accepted this cycle when i_req && o_ready
- o_issue_valid  out  4  one-hot dispatch, bit n = unit code n
- i_unit_ready  in  4  per-unit ready, same indexing
- o_issue_bundle  out  57  held bundle, stable while any o_issue_valid bit is high
- i_wb_valid  in  1  a unit writes back this cycle
- i_wb_rd  in  5  writeback destination; clears scoreboard bit
- i_redirect  in  1  branch resolved, fetch redirected (single-cycle pulse)
- o_trap  out  1  illegal instruction held; level
- i_trap_ack  in  1  trap handler consumed the trap

## Operation
- States: EMPTY, HOLD, BR_WAIT, TRAP. Reset → EMPTY.
- EMPTY: o_ready=1. On i_req:
  - i_valid=0, or unit≥4 (system/undefined): latch bundle, go to TRAP.
  - Otherwise: latch bundle, go to HOLD.
- HOLD: hazard = busy[rs1] | busy[rs2] | busy[rd]. Both source fields are checked regardless of format; the spurious stall is accepted. Bit 0 always reads not-busy.
  - No hazard: o_issue_valid[unit]=1.
  - Fire = o_issue_valid[unit] && i_unit_ready[unit]. On fire, set busy[rd] if rd≠0.
  - If branch=1, go to BR_WAIT.
  - Otherwise go to EMPTY, or accept a new i_req in the same cycle: o_ready=fire && !branch, and the new request is classified exactly as in EMPTY.
- BR_WAIT: o_ready=0, no issue. i_redirect → EMPTY.
- TRAP: o_trap=1, o_ready=0, no issue. i_trap_ack → EMPTY. Scoreboard is untouched, so outstanding writebacks still clear.
- Scoreboard:
  - i_wb_valid clears busy[i_wb_rd] in all states.
  - Same-cycle set and clear of the same index: set wins.
  - A writeback to rd=0 is ignored.
- o_issue_valid never has more than one bit set. It is never asserted outside HOLD.
- i_redirect outside BR_WAIT and i_trap_ack outside TRAP are ignored.

## Timing
- Reset values: o_ready=1 (EMPTY), o_issue_valid=0, o_issue_bundle=0, o_trap=0, scoreboard all-zero.
- Async reset mid-handshake drops o_issue_valid immediately and discards the held bundle.
- Accept-to-issue latency: 1 cycle minimum (accept in cycle N, o_issue_valid in N+1).
- Hazard stall: writeback in cycle W clears the bit at edge W+1. A dependent op issues in W+1 (W with bypass).
- Back-to-back independent ops sustain 1 issue/cycle.
- A unit holding ready low stalls HOLD indefinitely. Bundle and o_issue_valid stay stable; valid is never withdrawn without fire, except under reset.
- Trap asserts the cycle after the illegal accept and holds until the cycle after i_trap_ack.

## Configuration
- ISSUE_WB_BYPASS_EN defined: the HOLD hazard check uses busy & ~(same-cycle writeback mask), so a writeback releases a stalled dependent in the same cycle.
- Not defined: the check uses registered busy bits only, costing one extra stall cycle and keeping a shorter combinational path from i_wb_* to o_issue_valid.

## Structure
- Shared package risc_pkg:
  - unit codes UNIT_ASB=0, UNIT_LOGIC=1, UNIT_LOAD=2, UNIT_STORE=3
  - bundle width and field offset constants
  - issue state enum
- Sub-module issue_scoreboard:
  - contains the 32-bit busy vector, set/clear ports and x0 masking
  - two source-read ports plus one rd read port
  - bypass selected under ISSUE_WB_BYPASS_EN

## Test plan
- Reset, then ADD x3,x1,x2 (unit 0) with i_unit_ready=4'b0001 → o_issue_valid=4'b0001 one cycle after accept; busy[3]=1.
- Issue a LOAD to rd=5, then ADDI x6,x5,1 → ADDI held. Pulse i_wb_valid, i_wb_rd=5 in cycle W → issue in W+1, or in W with ISSUE_WB_BYPASS_EN.
- Hold i_unit_ready=0 for 10 cycles on a LOGIC op → o_issue_valid=4'b0010 and bundle stable all 10 cycles; o_ready=0. Fires when ready rises.
- i_req with i_valid=0 → o_trap=1, o_ready=0 until i_trap_ack. A writeback to a busy register during TRAP still clears it.
- Bundle with branch=1 issued → o_ready=0 until i_redirect. A redirect pulsed earlier, while in HOLD, is ignored.
- Deassert i_rst_n while o_issue_valid=4'b0100 → outputs return to reset values without waiting for a clock edge; scoreboard is zero.

Source files
------------

// File: rtl/risc_pkg.sv
// Shared constants, bundle layout and issue-state encoding for the dispatch path.
package risc_pkg;

  localparam int unsigned BUNDLE_W = 57;
  localparam int unsigned NREG     = 32;
  localparam int unsigned REG_W    = 5;
  localparam int unsigned UNIT_W   = 3;
  localparam int unsigned NUNIT    = 4;
  localparam int unsigned IMM_W    = 32;

  // Bit offsets of each field inside the flat decoder bundle
  localparam int unsigned RS1_LSB    = 52;
  localparam int unsigned RS2_LSB    = 47;
  localparam int unsigned RD_LSB     = 42;
  localparam int unsigned UNIT_LSB   = 39;
  localparam int unsigned OP_LSB     = 36;
  localparam int unsigned FUNC_LSB   = 33;
  localparam int unsigned IMM_LSB    = 1;
  localparam int unsigned BRANCH_BIT = 0;

  localparam logic [UNIT_W-1:0] UNIT_ASB   = 3'd0;
  localparam logic [UNIT_W-1:0] UNIT_LOGIC = 3'd1;
  localparam logic [UNIT_W-1:0] UNIT_LOAD  = 3'd2;
  localparam logic [UNIT_W-1:0] UNIT_STORE = 3'd3;

  typedef struct packed {
    logic [REG_W-1:0]  rs1;
    logic [REG_W-1:0]  rs2;
    logic [REG_W-1:0]  rd;
    logic [UNIT_W-1:0] unit;
    logic [2:0]        op;
    logic [2:0]        func;
    logic [IMM_W-1:0]  imm;
    logic              branch;
  } bundle_t;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_HOLD    = 2'd1,
    ST_BR_WAIT = 2'd2,
    ST_TRAP    = 2'd3
  } issue_state_e;

  // Units 4..7 are system/undefined and are routed to the trap path
  function automatic logic is_legal(input bundle_t b, input logic valid);
    return valid && (b.unit < UNIT_W'(NUNIT));
  endfunction

endpackage

// File: rtl/issue_ctrl_if.sv
// Decoder/execution-side signal bundle of the issue controller.
interface issue_ctrl_if;
  import risc_pkg::*;

  logic              i_req;
  bundle_t           i_bundle;
  logic              i_valid;
  logic              o_ready;
  logic [NUNIT-1:0]  o_issue_valid;
  logic [NUNIT-1:0]  i_unit_ready;
  bundle_t           o_issue_bundle;
  logic              i_wb_valid;
  logic [REG_W-1:0]  i_wb_rd;
  logic              i_redirect;
  logic              o_trap;
  logic              i_trap_ack;

  modport master (
    output i_req, i_bundle, i_valid, i_unit_ready, i_wb_valid, i_wb_rd,
           i_redirect, i_trap_ack,
    input  o_ready, o_issue_valid, o_issue_bundle, o_trap
  );

  modport slave (
    input  i_req, i_bundle, i_valid, i_unit_ready, i_wb_valid, i_wb_rd,
           i_redirect, i_trap_ack,
    output o_ready, o_issue_valid, o_issue_bundle, o_trap
  );

endinterface

// File: rtl/issue_scoreboard.sv
// 32-entry register busy vector with x0 masking and a three-port hazard read.
// ISSUE_WB_BYPASS_EN lets a same-cycle writeback hide its busy bit from the read.
module issue_scoreboard
  import risc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             set_en,
  input  logic [REG_W-1:0] set_idx,
  input  logic             clr_en,
  input  logic [REG_W-1:0] clr_idx,
  input  logic [REG_W-1:0] rs1_idx,
  input  logic [REG_W-1:0] rs2_idx,
  input  logic [REG_W-1:0] rd_idx,
  output logic             hazard_c
);

  logic [NREG-1:0] busy;
  logic [NREG-1:0] set_mask_c;
  logic [NREG-1:0] clr_mask_c;
  logic [NREG-1:0] view_c;

  // x0 is never tracked, so both masks drop bit 0
  always_comb begin
    set_mask_c = set_en ? (NREG'(1) << set_idx) : '0;
    clr_mask_c = clr_en ? (NREG'(1) << clr_idx) : '0;
    set_mask_c = set_mask_c & ~NREG'(1);
    clr_mask_c = clr_mask_c & ~NREG'(1);
  end

  // Set is applied after clear so it wins on the same index
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) busy <= '0;
    else        busy <= (busy & ~clr_mask_c) | set_mask_c;
  end

`ifdef ISSUE_WB_BYPASS_EN
  assign view_c = busy & ~clr_mask_c;
`else
  assign view_c = busy;
`endif

  assign hazard_c = view_c[rs1_idx] | view_c[rs2_idx] | view_c[rd_idx];

endmodule

// File: rtl/issue_ctrl.sv
// Single-issue dispatch controller: one-entry hold, hazard stall, branch/trap serialisation.
// Optional ISSUE_WB_BYPASS_EN (in issue_scoreboard) releases stalls in the writeback cycle.
module issue_ctrl
  import risc_pkg::*;
(
  input  logic         i_clk,
  input  logic         i_rst_n,
  issue_ctrl_if.slave  bus
);

  issue_state_e      state, state_nxt;
  bundle_t           held;
  logic              hazard_c;
  logic              fire_c;
  logic              ready_c;
  logic              accept_c;
  logic              legal_c;
  logic [NUNIT-1:0]  unit_oh_c;
  logic [NUNIT-1:0]  issue_valid_c;

  assign legal_c   = is_legal(bus.i_bundle, bus.i_valid);
  assign unit_oh_c = NUNIT'(1) << held.unit[1:0];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) state <= ST_EMPTY;
    else          state <= state_nxt;
  end

  // Next state, dispatch and ready; a HOLD that fires may accept in the same cycle
  always_comb begin
    state_nxt     = state;
    issue_valid_c = '0;
    fire_c        = 1'b0;
    ready_c       = 1'b0;
    case (state)
      ST_EMPTY: ready_c = 1'b1;
      ST_HOLD: begin
        if (!hazard_c) issue_valid_c = unit_oh_c;
        fire_c  = |(issue_valid_c & bus.i_unit_ready);
        ready_c = fire_c && !held.branch;
        if (fire_c) state_nxt = held.branch ? ST_BR_WAIT : ST_EMPTY;
      end
      ST_BR_WAIT: if (bus.i_redirect) state_nxt = ST_EMPTY;
      ST_TRAP:    if (bus.i_trap_ack) state_nxt = ST_EMPTY;
      default:    state_nxt = ST_EMPTY;
    endcase
    accept_c = bus.i_req && ready_c;
    if (accept_c) state_nxt = legal_c ? ST_HOLD : ST_TRAP;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n)      held <= '0;
    else if (accept_c) held <= bus.i_bundle;
  end

  issue_scoreboard u_sb (
    .clk      (i_clk),
    .rst_n    (i_rst_n),
    .set_en   (fire_c),
    .set_idx  (held.rd),
    .clr_en   (bus.i_wb_valid),
    .clr_idx  (bus.i_wb_rd),
    .rs1_idx  (held.rs1),
    .rs2_idx  (held.rs2),
    .rd_idx   (held.rd),
    .hazard_c (hazard_c)
  );

  assign bus.o_ready        = ready_c;
  assign bus.o_issue_valid  = issue_valid_c;
  assign bus.o_issue_bundle = held;
  assign bus.o_trap         = (state == ST_TRAP);

endmodule
